// File: rtl/bus_arb_pkg.sv
// Shared types and elaboration helpers for the N-requester bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam int REQ_MIN  = 2;
   localparam int REQ_MAX  = 16;
   localparam int TURN_MAX = 15;
   localparam int HOLD_MAX = 255;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit params_ok(input int n, input int rr, input int ta, input int mh);
      return (n >= REQ_MIN) && (n <= REQ_MAX) && (rr >= 0) && (rr <= 1) &&
             (ta >= 0) && (ta <= TURN_MAX) && (mh >= 0) && (mh <= HOLD_MAX);
   endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner picker: rotating priority from start when rr=1, lowest index otherwise.
// Zero latency; masked requesters are skipped, vld low when nothing eligible remains.
module arb_pick
   import bus_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] start,
   input  logic          rr,
   output logic [IW-1:0] idx,
   output logic          vld
);

   logic [N-1:0] eff;
   int           c;

   assign eff = req & ~mask;

   always_comb begin
      idx = '0;
      vld = 1'b0;
      c   = 0;
      for (int i = 0; i < N; i++) begin
         c = rr ? ((int'(start) + i) % N) : i;
         if (!vld && eff[c]) begin
            vld = 1'b1;
            idx = IW'(c);
         end
      end
   end

endmodule

// File: rtl/bus_arb_n.sv
// Shared-bus arbiter: registered one-hot grant one cycle after a request, optional turnaround and max-hold preemption.
// Requesters hold req until granted and for as long as they own the bus; there is no other backpressure.
module bus_arb_n
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int RR_MODE    = 1,
   parameter int TURNAROUND = 1,
   parameter int MAX_HOLD   = 0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         grant,
   output logic [idx_w(NUM_REQ)-1:0]  grant_idx,
   output logic                       busy,
   output logic                       preempt
);

   localparam int IW = idx_w(NUM_REQ);

   generate
      if (!params_ok(NUM_REQ, RR_MODE, TURNAROUND, MAX_HOLD)) begin : g_bad_params
         $error("bus_arb_n: parameter out of range");
      end
   endgenerate

   state_t               state;
   logic [7:0]           hold_cnt;
   logic [7:0]           hold_nxt;
   logic [3:0]           turn_cnt;
   logic [IW-1:0]        last_owner;
   logic [IW-1:0]        start;
   logic [NUM_REQ-1:0]   pmask;
   logic [NUM_REQ-1:0]   pick_mask;
   logic [NUM_REQ-1:0]   win_oh;
   logic [IW-1:0]        win_idx;
   logic                 win_vld;
   logic                 own_req;
   logic                 other_pend;
   logic                 preempt_now;
   logic                 rel;
   logic                 turn_last;
   logic                 decide;

   assign own_req     = |(req & grant);
   assign other_pend  = |(req & ~grant);
   // preempt was raised one cycle ahead; only act on it if a rival is still asking
   assign preempt_now = preempt && other_pend;
   assign rel         = (state == GRANT) && (!own_req || preempt_now);
   assign turn_last   = (state == TURN) && (turn_cnt == 4'(TURNAROUND - 1));
   assign decide      = (state == IDLE) || turn_last || (rel && (TURNAROUND == 0));
   assign pick_mask   = (state == GRANT) ? grant : pmask;
   assign start       = (last_owner == IW'(NUM_REQ - 1)) ? '0 : last_owner + 1'b1;
   assign hold_nxt    = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;

   always_comb begin
      win_oh          = '0;
      win_oh[win_idx] = 1'b1;
   end

   arb_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .mask  (pick_mask),
      .start (start),
      .rr    (RR_MODE != 0),
      .idx   (win_idx),
      .vld   (win_vld)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= '0;
         grant_idx  <= '0;
         busy       <= 1'b0;
         preempt    <= 1'b0;
         hold_cnt   <= '0;
         turn_cnt   <= '0;
         last_owner <= IW'(NUM_REQ - 1);
         pmask      <= '0;
      end else begin
         preempt <= 1'b0;
         if (decide) begin
            pmask <= '0;
            if (win_vld) begin
               state      <= GRANT;
               grant      <= win_oh;
               grant_idx  <= win_idx;
               busy       <= 1'b1;
               last_owner <= win_idx;
               hold_cnt   <= '0;
               preempt    <= (MAX_HOLD == 1) && (|(req & ~win_oh));
            end else begin
               state     <= IDLE;
               grant     <= '0;
               grant_idx <= '0;
               busy      <= 1'b0;
            end
         end else if (state == GRANT) begin
            if (rel) begin
               state     <= TURN;
               grant     <= '0;
               grant_idx <= '0;
               busy      <= 1'b0;
               turn_cnt  <= '0;
               pmask     <= preempt_now ? grant : '0;
            end else begin
               hold_cnt <= hold_nxt;
               preempt  <= (MAX_HOLD > 0) && (hold_nxt == 8'(MAX_HOLD - 1)) && other_pend;
            end
         end else if (state == TURN) begin
            turn_cnt <= turn_cnt + 4'd1;
         end
      end
   end

endmodule
